// File: rtl/hazard_unit_pkg.sv
// ----------------------------------------------------------------------------
// Module   : hazard_unit_pkg
// Brief    : Shared encodings, scoreboard entry type and helpers for hazard_unit
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

package hazard_unit_pkg;

  // Multi-cycle Execute operations; everything from ALU_MUL to ALU_SDIV is long.
  localparam logic [5:0] ALU_MUL   = 6'b100111;
  localparam logic [5:0] ALU_MLA   = 6'b101000;
  localparam logic [5:0] ALU_MLS   = 6'b101001;
  localparam logic [5:0] ALU_UMULL = 6'b101010;
  localparam logic [5:0] ALU_UMLAL = 6'b101011;
  localparam logic [5:0] ALU_SMULL = 6'b101100;
  localparam logic [5:0] ALU_SMLAL = 6'b101101;
  localparam logic [5:0] ALU_UDIV  = 6'b101110;
  localparam logic [5:0] ALU_SDIV  = 6'b101111;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  typedef enum logic [0:0] {
    LOP_IDLE = 1'b0,
    LOP_BUSY = 1'b1
  } lopState_t;

  typedef struct packed {
    logic       valid;
    logic [3:0] ra1;
    logic [3:0] ra2;
    logic [3:0] wa3;
  } sbEntry_t;

  function automatic logic isLongOp(input logic [5:0] op);
    return (op >= ALU_MUL) && (op <= ALU_SDIV);
  endfunction

  function automatic logic isDivOp(input logic [5:0] op);
    return (op == ALU_UDIV) || (op == ALU_SDIV);
  endfunction

  // M has priority over W so the youngest producer wins.
  function automatic logic [1:0] fwdSel(
    input logic [3:0] ra,
    input sbEntry_t   entM,
    input logic       regWriteM,
    input sbEntry_t   entW,
    input logic       regWriteW
  );
    if (entM.valid && regWriteM && (ra == entM.wa3))
      return FWD_M;
    else if (entW.valid && regWriteW && (ra == entW.wa3))
      return FWD_W;
    else
      return FWD_RF;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_unit_longop_sequencer.sv
// ----------------------------------------------------------------------------
// Module   : longop_sequencer
// Brief    : Holds Execute for the full latency of a multiply/divide operation
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module longop_sequencer
  import hazard_unit_pkg::*;
#(
  parameter int LAT_W = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             longE,
  input  logic [LAT_W-1:0] lat,
  output logic             lstall
);

  lopState_t        r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [LAT_W-1:0] w_latM2;

  // The detection cycle is the first stall cycle, so the counter starts at LAT-2.
  assign w_latM2 = lat - LAT_W'(2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= LOP_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        LOP_IDLE: begin
          if (longE) begin
            r_state <= LOP_BUSY;
            r_cnt   <= w_latM2[CNT_W-1:0];
          end
        end
        LOP_BUSY: begin
          if (r_cnt != '0)
            r_cnt <= r_cnt - CNT_W'(1);
          else
            r_state <= LOP_IDLE;
        end
        default: begin
          r_state <= LOP_IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    lstall = 1'b0;
    case (r_state)
      LOP_IDLE: lstall = longE;
      LOP_BUSY: lstall = (r_cnt != '0);
      default:  lstall = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hazard_unit.sv
// ----------------------------------------------------------------------------
// Module   : hazard_unit
// Brief    : Stall, flush and forwarding control for the 5-stage core
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`default_nettype none

module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3D,
  input  logic       RegWriteM,
  input  logic       RegWriteW,
  input  logic       MemtoRegE,
  input  logic       PCWrPendingF,
  input  logic       BranchTakenE,
  input  logic       PCSrcW,
  input  logic [5:0] ALUControlE,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       StallE,
  output logic       FlushD,
  output logic       FlushE,
  output logic       BubbleM
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int LAT_W   = $clog2(MAX_LAT + 1);
  localparam int CNT_W   = $clog2(MAX_LAT);

  localparam logic [LAT_W-1:0] C_MUL_LAT = LAT_W'(MUL_LAT);
  localparam logic [LAT_W-1:0] C_DIV_LAT = LAT_W'(DIV_LAT);

  sbEntry_t         r_sbE;
  sbEntry_t         r_sbM;
  sbEntry_t         r_sbW;
  sbEntry_t         w_sbD;
  logic             w_ldstall;
  logic             w_longE;
  logic             w_lstall;
  logic             w_flushE;
  logic [LAT_W-1:0] w_lat;

  assign w_sbD = '{valid: 1'b1, ra1: RA1D, ra2: RA2D, wa3: WA3D};

  // Scoreboard mirrors the pipeline registers; M takes a bubble while E is held.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sbE <= '0;
      r_sbM <= '0;
      r_sbW <= '0;
    end else begin
      r_sbW <= r_sbM;
      if (w_lstall) begin
        r_sbM <= '0;
      end else begin
        r_sbM <= r_sbE;
        r_sbE <= w_flushE ? '0 : w_sbD;
      end
    end
  end

  always_comb begin
    w_ldstall = r_sbE.valid && MemtoRegE &&
                ((RA1D == r_sbE.wa3) || (RA2D == r_sbE.wa3));
    w_longE   = r_sbE.valid && isLongOp(ALUControlE);
    w_lat     = isDivOp(ALUControlE) ? C_DIV_LAT : C_MUL_LAT;
  end

  longop_sequencer #(
    .LAT_W (LAT_W),
    .CNT_W (CNT_W)
  ) u_longop_sequencer (
    .clk    (clk),
    .reset  (reset),
    .longE  (w_longE),
    .lat    (w_lat),
    .lstall (w_lstall)
  );

  // A held long op must survive a load-use hit from D, so lstall masks FlushE.
  assign w_flushE = (w_ldstall || BranchTakenE) && !w_lstall;

  always_comb begin
    ForwardAE = fwdSel(r_sbE.ra1, r_sbM, RegWriteM, r_sbW, RegWriteW);
    ForwardBE = fwdSel(r_sbE.ra2, r_sbM, RegWriteM, r_sbW, RegWriteW);
    StallF    = w_ldstall || PCWrPendingF || w_lstall;
    StallD    = w_ldstall || w_lstall;
    StallE    = w_lstall;
    BubbleM   = w_lstall;
    FlushD    = PCWrPendingF || PCSrcW || BranchTakenE;
    FlushE    = w_flushE;
  end

endmodule

`default_nettype wire
